// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: runs a W-bit add/subtract through one external 8-bit CLA,
// least-significant byte first, chaining the carry through a register.
module cla_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IW-1:0]   idx_r;
  logic            carry_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    beff_r;
  logic [W-1:0]    result_r;
  logic            carry_out_r;
  logic            overflow_r;
  logic            busy_r;
  logic            done_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status flags registered from the next state so they line up with RUN/DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN) || (state_s == DONE);
      done_r <= (state_s == DONE);
    end
  end

  // Operand latch, byte walk and result accumulation; B is stored already inverted for subtract
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      beff_r      <= '0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= op_a;
            beff_r  <= op_b ^ {W{sub}};
            carry_r <= sub;
            idx_r   <= '0;
          end
        end
        RUN: begin
          result_r[{idx_r, 3'b000} +: 8] <= add_sum;
          carry_r <= add_cout;
          if (idx_r == LAST_IDX) begin
            carry_out_r <= add_cout;
            overflow_r  <= (a_r[W-1] == beff_r[W-1]) && (add_sum[7] != a_r[W-1]);
            idx_r       <= '0;
          end else begin
            idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          idx_r <= '0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  // Adder drive: only the current byte while running, quiet otherwise
  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (state_r == RUN) begin
      add_a   = a_r[{idx_r, 3'b000} +: 8];
      add_b   = beff_r[{idx_r, 3'b000} +: 8];
      add_cin = carry_r;
    end else begin
      add_a   = 8'h00;
      add_b   = 8'h00;
      add_cin = 1'b0;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: drives cla_seq_ctrl with an 8-bit adder model and checks it
// against whole-word arithmetic computed in the bench.
module tb_cla_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;
  localparam int LAT = NB + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic          add_cin;
  logic [7:0]    add_sum;
  logic          add_cout;

  int checks = 0;
  int passed = 0;

  cla_seq_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // External 8-bit adder
  always_comb begin
    {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-word reference: returns {overflow, carry_out, result}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic         ovf;
    be   = b ^ {W{s}};
    full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, s};
    ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  // Issue one operation and wait for done; lat counts cycles from acceptance
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat, output int busy_bad, output logic [16:0] drive0);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive0 = {add_a, add_b, add_cin};
    op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
    lat = 1;
    busy_bad = 0;
    while (!done && lat < 20) begin
      if (!busy) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = 99;
    else if (!busy) busy_bad++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result, carry_out, overflow, add_a, add_b, add_cin} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b result=%h co=%b ov=%b a=%h b=%h cin=%b exp all 0",
               busy, done, result, carry_out, overflow, add_a, add_b, add_cin);
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0005, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [W-1:0] tb [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h0000_0001};
    logic         ts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] er [5] = '{32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF};
    logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, bb;
    logic [16:0] d0;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], ts[i], lat, bb, d0);
      checks++;
      if (lat !== LAT) $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, LAT);
      else passed++;
      checks++;
      if ({result, carry_out, overflow} !== {er[i], ec[i], eo[i]})
        $display("FAIL dir%0d_result got %h/%b/%b exp %h/%b/%b", i, result, carry_out, overflow, er[i], ec[i], eo[i]);
      else passed++;
      checks++;
      if (bb !== 0) $display("FAIL dir%0d_busy got %0d low cycles exp 0", i, bb);
      else passed++;
      @(negedge clk);
      checks++;
      if ({done, busy, add_a, add_b, add_cin} !== '0)
        $display("FAIL dir%0d_after_done got done=%b busy=%b a=%h b=%h cin=%b exp 0", i, done, busy, add_a, add_b, add_cin);
      else passed++;
      checks++;
      if (result !== er[i]) $display("FAIL dir%0d_hold got %h exp %h", i, result, er[i]);
      else passed++;
    end
  endtask

  task automatic test_adder_drive();
    logic [W-1:0] a, b;
    logic s;
    int lat, bb;
    logic [16:0] d0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; s = 1'(i);
      run_op(a, b, s, lat, bb, d0);
      checks++;
      if (d0 !== {a[7:0], b[7:0] ^ {8{s}}, s})
        $display("FAIL drive%0d_byte0 got %h exp %h", i, d0, {a[7:0], b[7:0] ^ {8{s}}, s});
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic s;
    logic [W+1:0] exp;
    int lat, bb;
    logic [16:0] d0;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i % 5 == 0) b = a;
      if (i % 7 == 0) a = {1'b0, {(W-1){1'b1}}};
      exp = model(a, b, s);
      run_op(a, b, s, lat, bb, d0);
      checks++;
      if ({overflow, carry_out, result} !== exp || lat !== LAT)
        $display("FAIL rand%0d got ov/co/res=%b/%b/%h lat=%0d exp %b/%b/%h lat=%0d (a=%h b=%h sub=%b)",
                 i, overflow, carry_out, result, lat, exp[W+1], exp[W], exp[W-1:0], LAT, a, b, s);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    localparam int NC = 26;
    logic [W-1:0] va [NC];
    logic [W-1:0] vb [NC];
    logic         vs [NC];
    logic         edone [NC];
    logic         ebusy [NC];
    logic [W+1:0] eres [NC];
    int next_acc, ndone, nexp;
    @(negedge clk);
    for (int j = 0; j < NC; j++) begin
      va[j] = $urandom; vb[j] = $urandom; vs[j] = 1'($urandom);
      edone[j] = 1'b0; ebusy[j] = 1'b0; eres[j] = '0;
    end
    // An accepted op occupies NB run cycles plus one done cycle, then one idle cycle
    next_acc = 0; nexp = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == next_acc) begin
        for (int j = k; j <= k + NB; j++) ebusy[j] = 1'b1;
        edone[k + NB] = 1'b1;
        eres[k + NB] = model(va[k], vb[k], vs[k]);
        next_acc = k + NB + 2;
        nexp++;
      end
    end
    ndone = 0;
    for (int j = 0; j < NC; j++) begin
      start = (j < 20); op_a = va[j]; op_b = vb[j]; sub = vs[j];
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
      checks++;
      if ({busy, done} !== {ebusy[j], edone[j]})
        $display("FAIL b2b_cycle%0d got busy=%b done=%b exp %b %b", j, busy, done, ebusy[j], edone[j]);
      else passed++;
      if (edone[j]) begin
        checks++;
        if ({overflow, carry_out, result} !== eres[j])
          $display("FAIL b2b_result%0d got %b/%b/%h exp %b/%b/%h", j, overflow, carry_out, result,
                   eres[j][W+1], eres[j][W], eres[j][W-1:0]);
        else passed++;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== nexp) $display("FAIL b2b_done_count got %0d exp %0d", ndone, nexp);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    int seen, lat, bb;
    logic [16:0] d0;
    logic [W-1:0] a, b;
    logic [W+1:0] exp;
    @(negedge clk);
    op_a = 32'h1234_5678; op_b = 32'h0F0F_0F0F; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, carry_out, overflow, add_a, add_b, add_cin} !== '0)
      $display("FAIL midrun_async_clear got busy=%b done=%b result=%h co=%b ov=%b a=%h b=%h cin=%b exp all 0",
               busy, done, result, carry_out, overflow, add_a, add_b, add_cin);
    else passed++;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL midrun_no_done got %0d active cycles exp 0", seen);
    else passed++;
    a = $urandom; b = $urandom;
    exp = model(a, b, 1'b1);
    run_op(a, b, 1'b1, lat, bb, d0);
    checks++;
    if ({overflow, carry_out, result} !== exp || lat !== LAT)
      $display("FAIL midrun_fresh_op got %b/%b/%h lat=%0d exp %b/%b/%h lat=%0d",
               overflow, carry_out, result, lat, exp[W+1], exp[W], exp[W-1:0], LAT);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_adder_drive();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
